// File: rtl/two_port_request_queue.sv
// two_port_request_queue: two independent FIFOs feeding a 2-request arbiter, with a registered pop output.
// Define QUEUE_ERROR_FLAG_EN to add a sticky err output for dropped pushes and bad grants.
module two_port_request_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       push,
  input  logic [WIDTH-1:0] push_data0,
  input  logic [WIDTH-1:0] push_data1,
  output logic [1:0]       full,
  output logic [1:0]       requests,
  input  logic [1:0]       grants,
  output logic             pop_valid,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_port
`ifdef QUEUE_ERROR_FLAG_EN
  ,
  output logic             err
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0]    rptr_q [2];
  logic [AW-1:0]    rptr_d [2];
  logic [AW-1:0]    wptr_q [2];
  logic [AW-1:0]    wptr_d [2];
  logic [CW-1:0]    cnt_q  [2];
  logic [CW-1:0]    cnt_d  [2];
  logic [WIDTH-1:0] mem_q  [2][DEPTH];
  logic [WIDTH-1:0] wdata  [2];
  logic [1:0]       push_en, pop_en;
  logic             pop_valid_q, pop_valid_d, pop_port_q, pop_port_d;
  logic [WIDTH-1:0] pop_data_q, pop_data_d;
  assign wdata[0] = push_data0;
  assign wdata[1] = push_data1;
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      full[i]     = cnt_q[i] == CW'(DEPTH);
      requests[i] = cnt_q[i] != '0;
    end
    push_en = push & ~full;
    // grants = 11 is illegal and pops nothing; otherwise at most one bit survives
    pop_en  = grants & requests & {2{grants != 2'b11}};
    for (int i = 0; i < 2; i++) begin
      wptr_d[i] = wptr_q[i] + AW'(push_en[i]);
      rptr_d[i] = rptr_q[i] + AW'(pop_en[i]);
      cnt_d[i]  = cnt_q[i] + CW'(push_en[i]) - CW'(pop_en[i]);
    end
    pop_valid_d = |pop_en;
    pop_port_d  = |pop_en ? pop_en[1] : pop_port_q;
    pop_data_d  = pop_en[1] ? mem_q[1][rptr_q[1]] : pop_en[0] ? mem_q[0][rptr_q[0]] : pop_data_q;
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (push_en[i]) mem_q[i][wptr_q[i]] <= wdata[i];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        rptr_q[i] <= '0;
        wptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      pop_valid_q <= 1'b0;
      pop_port_q  <= 1'b0;
      pop_data_q  <= '0;
    end else begin
      rptr_q      <= rptr_d;
      wptr_q      <= wptr_d;
      cnt_q       <= cnt_d;
      pop_valid_q <= pop_valid_d;
      pop_port_q  <= pop_port_d;
      pop_data_q  <= pop_data_d;
    end
  end
  assign pop_valid = pop_valid_q;
  assign pop_port  = pop_port_q;
  assign pop_data  = pop_data_q;
`ifdef QUEUE_ERROR_FLAG_EN
  logic err_q, err_d;
  always_comb err_d = err_q | (|(push & full)) | (grants == 2'b11) | (|(grants & ~requests));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end
  assign err = err_q;
`endif
endmodule

// File: tb/tb_two_port_request_queue.sv
// tb_two_port_request_queue: directed scenario tasks with hand-computed expectations.
module tb_two_port_request_queue;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] push = 2'b00;
  logic [1:0] grants = 2'b00;
  logic [7:0] d0 = 8'h00;
  logic [7:0] d1 = 8'h00;
  logic [1:0] full, requests;
  logic       pop_valid, pop_port;
  logic [7:0] pop_data;
`ifdef QUEUE_ERROR_FLAG_EN
  logic       err;
`endif
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  two_port_request_queue #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .push(push), .push_data0(d0), .push_data1(d1),
    .full(full), .requests(requests), .grants(grants),
    .pop_valid(pop_valid), .pop_data(pop_data), .pop_port(pop_port)
`ifdef QUEUE_ERROR_FLAG_EN
    , .err(err)
`endif
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    push = 2'b00;
    grants = 2'b00;
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    step();
    step();
    checks++; if (full !== 2'b00) begin failures++; $display("FAIL reset_full got=%b exp=00", full); end
    checks++; if (requests !== 2'b00) begin failures++; $display("FAIL reset_requests got=%b exp=00", requests); end
    checks++; if (pop_valid !== 1'b0) begin failures++; $display("FAIL reset_pop_valid got=%b exp=0", pop_valid); end
    checks++; if (pop_data !== 8'h00) begin failures++; $display("FAIL reset_pop_data got=%h exp=00", pop_data); end
    checks++; if (pop_port !== 1'b0) begin failures++; $display("FAIL reset_pop_port got=%b exp=0", pop_port); end
`ifdef QUEUE_ERROR_FLAG_EN
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
`endif
    rst = 1'b1;
  endtask

  task automatic test_basic;
    push = 2'b01; d0 = 8'hA1;
    step();
    push = 2'b00;
    checks++; if (requests !== 2'b01) begin failures++; $display("FAIL basic_requests got=%b exp=01", requests); end
    checks++; if (pop_valid !== 1'b0) begin failures++; $display("FAIL basic_no_pop got=%b exp=0", pop_valid); end
    grants = 2'b01;
    step();
    grants = 2'b00;
    checks++; if (pop_valid !== 1'b1) begin failures++; $display("FAIL basic_pop_valid got=%b exp=1", pop_valid); end
    checks++; if (pop_data !== 8'hA1) begin failures++; $display("FAIL basic_pop_data got=%h exp=a1", pop_data); end
    checks++; if (pop_port !== 1'b0) begin failures++; $display("FAIL basic_pop_port got=%b exp=0", pop_port); end
    checks++; if (requests !== 2'b00) begin failures++; $display("FAIL basic_requests_empty got=%b exp=00", requests); end
`ifdef QUEUE_ERROR_FLAG_EN
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL basic_err got=%b exp=0", err); end
`endif
    step();
    checks++; if (pop_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_drop got=%b exp=0", pop_valid); end
    checks++; if (pop_data !== 8'hA1) begin failures++; $display("FAIL basic_data_hold got=%h exp=a1", pop_data); end
  endtask

  task automatic test_wrap;
    logic [7:0] v;
    push = 2'b01; d0 = 8'h00;
    step();
    for (int k = 1; k <= 5; k++) begin
      v = 8'(k);
      push = 2'b01; d0 = v; grants = 2'b01;
      step();
      checks++; if (pop_valid !== 1'b1 || pop_data !== v - 8'h01) begin failures++; $display("FAIL wrap_simul_pop%0d got=%b/%h exp=1/%h", k, pop_valid, pop_data, v - 8'h01); end
      checks++; if (requests !== 2'b01 || full !== 2'b00) begin failures++; $display("FAIL wrap_simul_count%0d got=%b/%b exp=01/00", k, requests, full); end
    end
    push = 2'b00; grants = 2'b01;
    step();
    grants = 2'b00;
    checks++; if (pop_data !== 8'h05 || requests !== 2'b00) begin failures++; $display("FAIL wrap_tail got=%h/%b exp=05/00", pop_data, requests); end
    for (int k = 0; k < 5; k++) begin
      v = 8'h60 + 8'(k);
      push = 2'b10; d1 = v;
      step();
      push = 2'b00; grants = 2'b10;
      step();
      grants = 2'b00;
      checks++; if (pop_valid !== 1'b1 || pop_data !== v || pop_port !== 1'b1) begin failures++; $display("FAIL wrap_alt%0d got=%b/%h/%b exp=1/%h/1", k, pop_valid, pop_data, pop_port, v); end
    end
  endtask

  task automatic test_alternate;
    logic [1:0] g;
    logic       last;
    logic [7:0] exp_data [4];
    logic       exp_port [4];
    exp_data[0] = 8'h20; exp_data[1] = 8'h30; exp_data[2] = 8'h21; exp_data[3] = 8'h31;
    exp_port[0] = 1'b0;  exp_port[1] = 1'b1;  exp_port[2] = 1'b0;  exp_port[3] = 1'b1;
    push = 2'b11; d0 = 8'h20; d1 = 8'h30;
    step();
    d0 = 8'h21; d1 = 8'h31;
    step();
    push = 2'b00;
    last = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (last) g = requests[0] ? 2'b01 : (requests[1] ? 2'b10 : 2'b00);
      else      g = requests[1] ? 2'b10 : (requests[0] ? 2'b01 : 2'b00);
      grants = g;
      step();
      if (g != 2'b00) last = g[1];
      checks++; if (pop_valid !== 1'b1 || pop_port !== exp_port[k] || pop_data !== exp_data[k]) begin failures++; $display("FAIL alt_pop%0d got=%b/%b/%h exp=1/%b/%h", k, pop_valid, pop_port, pop_data, exp_port[k], exp_data[k]); end
    end
    grants = 2'b00;
    checks++; if (requests !== 2'b00) begin failures++; $display("FAIL alt_drained got=%b exp=00", requests); end
  endtask

  task automatic test_full;
    for (int k = 0; k < 5; k++) begin
      push = 2'b10; d1 = 8'h10 + 8'(k);
      step();
      if (k == 2) begin
        checks++; if (full !== 2'b00) begin failures++; $display("FAIL full_early got=%b exp=00", full); end
      end
      if (k == 3) begin
        checks++; if (full !== 2'b10) begin failures++; $display("FAIL full_after4 got=%b exp=10", full); end
      end
    end
    push = 2'b00;
    checks++; if (full !== 2'b10 || requests !== 2'b10) begin failures++; $display("FAIL full_hold got=%b/%b exp=10/10", full, requests); end
`ifdef QUEUE_ERROR_FLAG_EN
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL full_err got=%b exp=1", err); end
`endif
    grants = 2'b10;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (pop_valid !== 1'b1 || pop_port !== 1'b1 || pop_data !== 8'h10 + 8'(k)) begin failures++; $display("FAIL full_pop%0d got=%b/%b/%h exp=1/1/%h", k, pop_valid, pop_port, pop_data, 8'h10 + 8'(k)); end
    end
    grants = 2'b00;
    checks++; if (requests !== 2'b00 || full !== 2'b00) begin failures++; $display("FAIL full_drained got=%b/%b exp=00/00", requests, full); end
  endtask

  task automatic test_full_pop;
    do_reset();
`ifdef QUEUE_ERROR_FLAG_EN
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL fullpop_err_clear got=%b exp=0", err); end
`endif
    for (int k = 0; k < 4; k++) begin
      push = 2'b01; d0 = 8'h40 + 8'(k);
      step();
    end
    checks++; if (full !== 2'b01) begin failures++; $display("FAIL fullpop_full got=%b exp=01", full); end
    push = 2'b01; d0 = 8'h44; grants = 2'b01;
    step();
    push = 2'b00;
    checks++; if (pop_data !== 8'h40 || full !== 2'b00 || requests !== 2'b01) begin failures++; $display("FAIL fullpop_first got=%h/%b/%b exp=40/00/01", pop_data, full, requests); end
`ifdef QUEUE_ERROR_FLAG_EN
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL fullpop_err got=%b exp=1", err); end
`endif
    for (int k = 1; k < 4; k++) begin
      step();
      checks++; if (pop_valid !== 1'b1 || pop_data !== 8'h40 + 8'(k)) begin failures++; $display("FAIL fullpop_pop%0d got=%b/%h exp=1/%h", k, pop_valid, pop_data, 8'h40 + 8'(k)); end
    end
    step();
    grants = 2'b00;
    checks++; if (pop_valid !== 1'b0 || requests !== 2'b00) begin failures++; $display("FAIL fullpop_dropped got=%b/%b exp=0/00", pop_valid, requests); end
  endtask

  task automatic test_illegal;
    do_reset();
    grants = 2'b10;
    step();
    grants = 2'b00;
    checks++; if (pop_valid !== 1'b0 || requests !== 2'b00) begin failures++; $display("FAIL empty_grant got=%b/%b exp=0/00", pop_valid, requests); end
`ifdef QUEUE_ERROR_FLAG_EN
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL empty_grant_err got=%b exp=1", err); end
`endif
    do_reset();
    push = 2'b11; d0 = 8'h50; d1 = 8'h60;
    step();
    push = 2'b00; grants = 2'b11;
    step();
    checks++; if (pop_valid !== 1'b0 || requests !== 2'b11) begin failures++; $display("FAIL grant11 got=%b/%b exp=0/11", pop_valid, requests); end
`ifdef QUEUE_ERROR_FLAG_EN
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL grant11_err got=%b exp=1", err); end
`endif
    grants = 2'b01;
    step();
    checks++; if (pop_data !== 8'h50 || pop_port !== 1'b0 || requests !== 2'b10) begin failures++; $display("FAIL grant11_after0 got=%h/%b/%b exp=50/0/10", pop_data, pop_port, requests); end
    grants = 2'b10;
    step();
    grants = 2'b00;
    checks++; if (pop_data !== 8'h60 || pop_port !== 1'b1 || requests !== 2'b00) begin failures++; $display("FAIL grant11_after1 got=%h/%b/%b exp=60/1/00", pop_data, pop_port, requests); end
  endtask

  task automatic test_async_reset;
    push = 2'b11; d0 = 8'h70; d1 = 8'h80;
    step();
    d0 = 8'h71; d1 = 8'h81;
    step();
    push = 2'b00; grants = 2'b01;
    step();
    grants = 2'b00;
    checks++; if (pop_valid !== 1'b1 || requests !== 2'b11) begin failures++; $display("FAIL areset_pre got=%b/%b exp=1/11", pop_valid, requests); end
    #2 rst = 1'b0;
    #1;
    checks++; if (requests !== 2'b00 || pop_valid !== 1'b0 || full !== 2'b00) begin failures++; $display("FAIL areset_now got=%b/%b/%b exp=00/0/00", requests, pop_valid, full); end
    #1 rst = 1'b1;
    push = 2'b01; d0 = 8'h90;
    step();
    d0 = 8'h91;
    step();
    push = 2'b00;
    checks++; if (requests !== 2'b01) begin failures++; $display("FAIL areset_requests got=%b exp=01", requests); end
    grants = 2'b01;
    step();
    checks++; if (pop_data !== 8'h90) begin failures++; $display("FAIL areset_first got=%h exp=90", pop_data); end
    step();
    grants = 2'b00;
    checks++; if (pop_data !== 8'h91 || requests !== 2'b00) begin failures++; $display("FAIL areset_second got=%h/%b exp=91/00", pop_data, requests); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_alternate();
    test_full();
    test_full_pop();
    test_illegal();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
